// File: rtl/song_pkg.sv
// Shared types and constants for the song sequencer: FSM states, note-table entry layout
// and named note frequencies used to author melodies.
package song_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    PLAY,
    GAP,
    END
  } state_e;

  localparam int unsigned ENTRY_W   = 16;
  localparam int unsigned HZ_W      = 12;
  localparam int unsigned BEATS_W   = 4;

  localparam int unsigned HZ_MSB    = 15;
  localparam int unsigned HZ_LSB    = 4;
  localparam int unsigned BEATS_MSB = 3;
  localparam int unsigned BEATS_LSB = 0;

  localparam logic [BEATS_W-1:0] END_BEATS = '0;

  localparam logic [HZ_W-1:0] NOTE_REST = 12'd0;
  localparam logic [HZ_W-1:0] NOTE_C4   = 12'd262;
  localparam logic [HZ_W-1:0] NOTE_D4   = 12'd294;
  localparam logic [HZ_W-1:0] NOTE_E4   = 12'd330;
  localparam logic [HZ_W-1:0] NOTE_F4   = 12'd349;
  localparam logic [HZ_W-1:0] NOTE_G4   = 12'd392;
  localparam logic [HZ_W-1:0] NOTE_A4   = 12'd440;

  function automatic logic [ENTRY_W-1:0] mk_entry(input logic [HZ_W-1:0]    hz,
                                                  input logic [BEATS_W-1:0] beats);
    return {hz, beats};
  endfunction

endpackage

// File: rtl/song_rom.sv
// Synchronous note-table ROM, one 2^ADDR_W-entry table per song, 1-cycle read latency.
// Melodies live here so they can be edited without touching the sequencer FSM.
module song_rom
  import song_pkg::*;
#(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned SONG_W = 2
) (
  input  logic                clk,
  input  logic [SONG_W-1:0]   song_sel,
  input  logic [ADDR_W-1:0]   addr,
  output logic [ENTRY_W-1:0]  data
);

  // Any entry not listed reads as 0, i.e. the END marker.
  function automatic logic [ENTRY_W-1:0] lookup(input int unsigned song, input int unsigned idx);
    logic [ENTRY_W-1:0] e;
    e = '0;
    case (song)
      0: begin
        case (idx)
          0:       e = mk_entry(NOTE_A4, 4'd2);
          default: e = '0;
        endcase
      end
      1: begin
        case (idx)
          0:       e = mk_entry(NOTE_C4,   4'd1);
          1:       e = mk_entry(NOTE_REST, 4'd1);
          2:       e = mk_entry(NOTE_E4,   4'd1);
          default: e = '0;
        endcase
      end
      2: begin
        // Full-length scale with no END marker: exercises the implicit end at the last entry.
        e = mk_entry(12'(200 + 4 * idx), 4'(1 + (idx % 2)));
      end
      3: begin
        case (idx)
          0, 1:    e = mk_entry(NOTE_C4, 4'd1);
          2, 3:    e = mk_entry(NOTE_G4, 4'd1);
          4, 5:    e = mk_entry(NOTE_A4, 4'd1);
          6:       e = mk_entry(NOTE_G4, 4'd2);
          7, 8:    e = mk_entry(NOTE_F4, 4'd1);
          9, 10:   e = mk_entry(NOTE_E4, 4'd1);
          11, 12:  e = mk_entry(NOTE_D4, 4'd1);
          13:      e = mk_entry(NOTE_C4, 4'd2);
          default: e = '0;
        endcase
      end
      default: e = '0;
    endcase
    return e;
  endfunction

  // NOTE: the ROM read register carries no reset; the FSM only consumes it in DECODE,
  // one cycle after FETCH has presented a valid address, so its reset value is never observed.
  always_ff @(posedge clk) begin
    data <= lookup(32'(song_sel), 32'(addr));
  end

endmodule

// File: rtl/song_sequencer.sv
// Steps through the selected song's note table and drives hz_next to the buzzer player.
// Define SONG_SEQUENCER_LOOP_EN to loop the song forever instead of ending with song_done.
module song_sequencer
  import song_pkg::*;
#(
  parameter int unsigned TICKS_PER_BEAT = 25_000_000,
  parameter int unsigned GAP_TICKS      = 2_000_000,
  parameter int unsigned ADDR_W         = 6,
  parameter int unsigned SONG_W         = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic [SONG_W-1:0] song_sel,
  output logic [11:0]       hz_next,
  output logic              playing,
  output logic [ADDR_W-1:0] note_idx,
  output logic              song_done
);

  localparam logic [31:0]       BEAT_LAST = 32'(TICKS_PER_BEAT - 1);
  localparam logic [31:0]       PLAY_LAST = 32'(TICKS_PER_BEAT - GAP_TICKS - 1);
  localparam logic [31:0]       GAP_LAST  = 32'(GAP_TICKS - 1);
  localparam logic [ADDR_W-1:0] IDX_LAST  = {ADDR_W{1'b1}};

  state_e              state_q, state_d;
  logic [HZ_W-1:0]     hz_q, hz_d;
  logic                playing_q, playing_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic                done_q, done_d;
  logic [SONG_W-1:0]   song_sel_q, song_sel_d;
  logic [31:0]         tick_q, tick_d;
  logic [BEATS_W-1:0]  beat_q, beat_d;
  logic                song_end;

  logic [ENTRY_W-1:0]  rom_data;
  logic [HZ_W-1:0]     rom_hz;
  logic [BEATS_W-1:0]  rom_beats;

  song_rom #(
    .ADDR_W (ADDR_W),
    .SONG_W (SONG_W)
  ) u_rom (
    .clk      (clk),
    .song_sel (song_sel_q),
    .addr     (idx_q),
    .data     (rom_data)
  );

  assign rom_hz    = rom_data[HZ_MSB:HZ_LSB];
  assign rom_beats = rom_data[BEATS_MSB:BEATS_LSB];

  // NOTE: every signal assigned below gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    hz_d       = hz_q;
    playing_d  = playing_q;
    idx_d      = idx_q;
    done_d     = 1'b0;
    song_sel_d = song_sel_q;
    tick_d     = tick_q;
    beat_d     = beat_q;
    song_end   = 1'b0;

    case (state_q)
      IDLE: begin
        hz_d = '0;
        if (start && !stop) begin
          song_sel_d = song_sel;
          idx_d      = '0;
          playing_d  = 1'b1;
          state_d    = FETCH;
        end
      end

      FETCH: state_d = DECODE;

      DECODE: begin
        if (rom_beats == END_BEATS) begin
          song_end = 1'b1;
        end else begin
          hz_d    = rom_hz;
          tick_d  = '0;
          beat_d  = rom_beats;
          state_d = PLAY;
        end
      end

      PLAY: begin
        // The last beat is cut short by GAP_TICKS so the whole note still spans beats*TICKS_PER_BEAT.
        if (beat_q == 4'd1 && tick_q == PLAY_LAST) begin
          hz_d    = '0;
          tick_d  = '0;
          state_d = GAP;
        end else if (tick_q == BEAT_LAST) begin
          tick_d = '0;
          beat_d = beat_q - 4'd1;
        end else begin
          tick_d = tick_q + 32'd1;
        end
      end

      GAP: begin
        if (tick_q == GAP_LAST) begin
          tick_d = '0;
          if (idx_q == IDX_LAST) begin
            song_end = 1'b1;
          end else begin
            idx_d   = idx_q + ADDR_W'(1);
            state_d = FETCH;
          end
        end else begin
          tick_d = tick_q + 32'd1;
        end
      end

      END: begin
        playing_d = 1'b0;
        state_d   = IDLE;
      end

      default: state_d = IDLE;
    endcase

    if (song_end) begin
`ifdef SONG_SEQUENCER_LOOP_EN
      idx_d   = '0;
      state_d = FETCH;
`else
      done_d    = 1'b1;
      playing_d = 1'b0;
      state_d   = END;
`endif
    end

    // Abort has priority over everything, including a same-cycle start.
    if (stop && state_q != IDLE) begin
      state_d   = IDLE;
      hz_d      = '0;
      playing_d = 1'b0;
      idx_d     = '0;
      done_d    = 1'b0;
      tick_d    = '0;
      beat_d    = '0;
    end
  end

  // NOTE: reset is synchronous (sampled on the clock edge) and all state uses non-blocking updates.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      hz_q       <= '0;
      playing_q  <= 1'b0;
      idx_q      <= '0;
      done_q     <= 1'b0;
      song_sel_q <= '0;
      tick_q     <= '0;
      beat_q     <= '0;
    end else begin
      state_q    <= state_d;
      hz_q       <= hz_d;
      playing_q  <= playing_d;
      idx_q      <= idx_d;
      done_q     <= done_d;
      song_sel_q <= song_sel_d;
      tick_q     <= tick_d;
      beat_q     <= beat_d;
    end
  end

  assign hz_next   = hz_q;
  assign playing   = playing_q;
  assign note_idx  = idx_q;
  assign song_done = done_q;

endmodule

// File: tb/tb_song_sequencer.sv
// Self-checking bench for song_sequencer: a directed run-length vector table plus randomized
// start/stop traffic checked against a timeline model built from the note-table rules.
module tb_song_sequencer;

  localparam int T = 10;
  localparam int G = 2;
`ifdef SONG_SEQUENCER_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        stop;
  logic [1:0]  song_sel;
  logic [11:0] hz_next;
  logic        playing;
  logic [5:0]  note_idx;
  logic        song_done;

  always #5 clk = ~clk;

  song_sequencer #(
    .TICKS_PER_BEAT (T),
    .GAP_TICKS      (G),
    .ADDR_W         (6),
    .SONG_W         (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .stop      (stop),
    .song_sel  (song_sel),
    .hz_next   (hz_next),
    .playing   (playing),
    .note_idx  (note_idx),
    .song_done (song_done)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at t=%0t", name, got, exp, $time);
  endtask

  // Expected observable state for one cycle; busy marks a non-IDLE sequencer.
  typedef struct {
    bit          busy;
    logic [11:0] hz;
    bit          pl;
    logic [5:0]  idx;
    bit          done;
  } obs_t;

  function automatic obs_t mk_obs(input bit busy, input int hz, input bit pl, input int idx, input bit done);
    obs_t o;
    o.busy = busy; o.hz = 12'(hz); o.pl = pl; o.idx = 6'(idx); o.done = done;
    return o;
  endfunction

  task automatic check_obs(input string tag, input obs_t e);
    check({tag, ".hz_next"},   32'(hz_next),   32'(e.hz));
    check({tag, ".playing"},   32'(playing),   32'(e.pl));
    check({tag, ".note_idx"},  32'(note_idx),  32'(e.idx));
    check({tag, ".song_done"}, 32'(song_done), 32'(e.done));
  endtask

  // Reference copy of the melodies: {hz, beats}; beats 0 ends the song.
  function automatic logic [15:0] ref_entry(input int s, input int i);
    int tw_hz[14] = '{262, 262, 392, 392, 440, 440, 392, 349, 349, 330, 330, 294, 294, 262};
    int tw_bt[14] = '{1, 1, 1, 1, 1, 1, 2, 1, 1, 1, 1, 1, 1, 2};
    case (s)
      0: return (i == 0) ? {12'd440, 4'd2} : 16'd0;
      1: begin
        if (i == 0) return {12'd262, 4'd1};
        if (i == 1) return {12'd0,   4'd1};
        if (i == 2) return {12'd330, 4'd1};
        return 16'd0;
      end
      2: return {12'(200 + 4 * i), 4'(1 + i % 2)};
      default: return (i < 14) ? {12'(tw_hz[i]), 4'(tw_bt[i])} : 16'd0;
    endcase
  endfunction

  obs_t exp_q[$];
  obs_t cur;
  int   cur_song;

  // Expand one pass of a song into its per-cycle output timeline, starting with the first FETCH.
  task automatic push_pass(input int s);
    logic [15:0] e;
    int hz, b;
    for (int i = 0; i < 64; i++) begin
      e  = ref_entry(s, i);
      hz = int'(e[15:4]);
      b  = int'(e[3:0]);
      repeat (2) exp_q.push_back(mk_obs(1, 0, 1, i, 0));
      if (b == 0) begin
        if (!LOOP) exp_q.push_back(mk_obs(1, 0, 0, i, 1));
        return;
      end
      repeat (b * T - G) exp_q.push_back(mk_obs(1, hz, 1, i, 0));
      repeat (G) exp_q.push_back(mk_obs(1, 0, 1, i, 0));
    end
    if (!LOOP) exp_q.push_back(mk_obs(1, 0, 0, 63, 1));
  endtask

  task automatic step(input bit st, input bit sp, input logic [1:0] sel);
    obs_t nx;
    @(negedge clk);
    start = st; stop = sp; song_sel = sel;
    if (sp && cur.busy) begin
      exp_q.delete();
      nx = mk_obs(0, 0, 0, 0, 0);
    end else if (st && !sp && !cur.busy) begin
      exp_q.delete();
      cur_song = int'(sel);
      push_pass(cur_song);
      nx = exp_q.pop_front();
    end else if (exp_q.size() > 0) begin
      nx = exp_q.pop_front();
    end else if (LOOP && cur.busy) begin
      push_pass(cur_song);
      nx = exp_q.pop_front();
    end else begin
      nx = mk_obs(0, 0, 0, int'(cur.idx), 0);
    end
    @(posedge clk); #1;
    check_obs("model", nx);
    cur = nx;
  endtask

  typedef struct {
    bit          st;
    bit          sp;
    logic [1:0]  sel;
    int          n;
    logic [11:0] hz;
    bit          pl;
    logic [5:0]  idx;
    bit          done;
  } vec_t;

  function automatic vec_t mk_vec(input bit st, input bit sp, input int sel, input int n,
                                  input int hz, input bit pl, input int idx, input bit done);
    vec_t v;
    v.st = st; v.sp = sp; v.sel = 2'(sel); v.n = n;
    v.hz = 12'(hz); v.pl = pl; v.idx = 6'(idx); v.done = done;
    return v;
  endfunction

  vec_t vecs[$];

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; song_sel = 2'd0;
    cur = mk_obs(0, 0, 0, 0, 0);
    cur_song = 0;

    repeat (3) @(posedge clk);
    #1;
    check_obs("reset", mk_obs(0, 0, 0, 0, 0));
    @(negedge clk);
    rst_n = 1'b1;

`ifndef SONG_SEQUENCER_LOOP_EN
    // Inputs pulse on a row's first cycle; expectations hold for all n cycles of the row.
    vecs.push_back(mk_vec(1, 0, 0,  2,   0, 1, 0, 0));  // song 0: FETCH/DECODE
    vecs.push_back(mk_vec(0, 0, 0, 18, 440, 1, 0, 0));
    vecs.push_back(mk_vec(0, 0, 0,  2,   0, 1, 0, 0));  // articulation gap
    vecs.push_back(mk_vec(0, 0, 0,  2,   0, 1, 1, 0));  // fetch of END marker
    vecs.push_back(mk_vec(0, 0, 0,  1,   0, 0, 1, 1));  // END
    vecs.push_back(mk_vec(0, 0, 0,  3,   0, 0, 1, 0));
    vecs.push_back(mk_vec(1, 1, 1,  3,   0, 0, 1, 0));  // start+stop from IDLE: ignored
    vecs.push_back(mk_vec(1, 0, 1,  2,   0, 1, 0, 0));  // song 1
    vecs.push_back(mk_vec(0, 0, 0,  5, 262, 1, 0, 0));
    vecs.push_back(mk_vec(0, 1, 0,  3,   0, 0, 0, 0));  // stop mid-note
    vecs.push_back(mk_vec(1, 0, 1,  2,   0, 1, 0, 0));  // replay from entry 0
    vecs.push_back(mk_vec(0, 0, 0,  8, 262, 1, 0, 0));
    vecs.push_back(mk_vec(0, 0, 0,  2,   0, 1, 0, 0));
    vecs.push_back(mk_vec(0, 0, 0, 12,   0, 1, 1, 0));  // rest entry
    vecs.push_back(mk_vec(0, 0, 0,  2,   0, 1, 2, 0));
    vecs.push_back(mk_vec(0, 0, 0,  4, 330, 1, 2, 0));
    vecs.push_back(mk_vec(1, 0, 0,  4, 330, 1, 2, 0));  // start while playing: ignored
    vecs.push_back(mk_vec(0, 0, 0,  2,   0, 1, 2, 0));
    vecs.push_back(mk_vec(0, 0, 0,  2,   0, 1, 3, 0));
    vecs.push_back(mk_vec(0, 0, 0,  1,   0, 0, 3, 1));
    vecs.push_back(mk_vec(0, 0, 0,  2,   0, 0, 3, 0));

    for (int r = 0; r < vecs.size(); r++) begin
      for (int k = 0; k < vecs[r].n; k++) begin
        @(negedge clk);
        start    = (k == 0) ? vecs[r].st : 1'b0;
        stop     = (k == 0) ? vecs[r].sp : 1'b0;
        song_sel = vecs[r].sel;
        @(posedge clk); #1;
        check_obs($sformatf("row%0d.c%0d", r, k),
                  mk_obs(0, int'(vecs[r].hz), vecs[r].pl, int'(vecs[r].idx), vecs[r].done));
      end
    end
    cur = mk_obs(0, 0, 0, 3, 0);
`endif

    // Song 0 under the model (loops when the loop feature is built in), then stop.
    step(1, 0, 0);
    repeat (60) step(0, 0, 0);
    step(0, 1, 0);
    repeat (3) step(0, 0, 0);

    // Song 2: 64 entries with no END marker, implicit end after the last gap.
    step(1, 0, 2);
    for (int k = 0; k < 1500 && cur.busy; k++) step(0, 0, 0);
    step(0, 1, 0);
    repeat (3) step(0, 0, 0);

    // Randomized start/stop/select traffic.
    for (int k = 0; k < 3000; k++) begin
      step($urandom_range(0, 15) == 0, $urandom_range(0, 99) == 0, 2'($urandom_range(0, 3)));
    end

    // Reset in the middle of a note silences everything on the next edge.
    step(0, 1, 0);
    step(1, 0, 3);
    repeat (10) step(0, 0, 0);
    @(negedge clk);
    rst_n = 1'b0; start = 1'b0; stop = 1'b0;
    @(posedge clk); #1;
    check_obs("mid_reset", mk_obs(0, 0, 0, 0, 0));
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    cur = mk_obs(0, 0, 0, 0, 0);
    step(1, 0, 3);
    repeat (40) step(0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
